// File: rtl/sys_array_lock_arbiter_pkg.sv
// Shared definitions for the systolic-array lock arbiter: slot count and
// the per-channel lock state encoding.
package sys_array_lock_arbiter_pkg;

    localparam int NUM_SLOTS = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } chan_state_t;

endpackage

// File: rtl/sys_array_lock_arbiter_rr_lock_channel.sv
// One lockable resource: two-slot round-robin arbiter, grant held until the
// controller's finished pulse, payload latched for the winner.
// Optional busy timeout under SYS_ARB_TIMEOUT_EN.
module rr_lock_channel
    import sys_array_lock_arbiter_pkg::*;
#(
    parameter int PAYLOAD_W      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_SLOTS-1:0]           req,
    input  logic [NUM_SLOTS*PAYLOAD_W-1:0] payload_in,
    input  logic                           finished,
    output logic [NUM_SLOTS-1:0]           grant,
    output logic                           start,
    output logic [PAYLOAD_W-1:0]           payload_out,
    output logic                           timeout
);

    chan_state_t state;
    logic        last_winner;
    logic        winner;

    // Sole requester wins; on contention the slot that did not win last time.
    // last_winner resets to 0, so a contended first request goes to slot 1.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) winner = ~last_winner;
    end

`ifdef SYS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] busy_cnt;
`endif

    // Lock FSM with registered grant/start/payload outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            start       <= 1'b0;
            payload_out <= '0;
            last_winner <= 1'b0;
            timeout     <= 1'b0;
`ifdef SYS_ARB_TIMEOUT_EN
            busy_cnt    <= '0;
`endif
        end else begin
            start   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state       <= ST_GRANT;
                        grant       <= winner ? 2'b10 : 2'b01;
                        payload_out <= winner ? payload_in[2*PAYLOAD_W-1:PAYLOAD_W]
                                              : payload_in[PAYLOAD_W-1:0];
                        last_winner <= winner;
                    end
                end
                ST_GRANT: begin
                    // finished is not looked at here; the start pulse shows
                    // during the first BUSY cycle.
                    state <= ST_BUSY;
                    start <= 1'b1;
`ifdef SYS_ARB_TIMEOUT_EN
                    busy_cnt <= '0;
`endif
                end
                ST_BUSY: begin
                    if (finished) begin
                        state <= ST_RELEASE;
                        grant <= '0;
                    end
`ifdef SYS_ARB_TIMEOUT_EN
                    else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state   <= ST_RELEASE;
                        grant   <= '0;
                        timeout <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    // Dead cycle so the released slot can drop its request.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sys_array_lock_arbiter.sv
// Arbitrates the systolic-array controller's compute and weight-load
// resources between two thread slots. Each resource is an independent
// rr_lock_channel; this level only slices address buses.
// Optional feature macro: SYS_ARB_TIMEOUT_EN (forced release after
// TIMEOUT_CYCLES busy cycles, reported on timeout_err).
module sys_array_lock_arbiter
    import sys_array_lock_arbiter_pkg::*;
#(
    parameter int BITWIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            comp_req,
    input  logic [6*BITWIDTH-1:0] comp_addrs,
    output logic [1:0]            comp_grant,
    output logic                  comp_start,
    output logic [BITWIDTH-1:0]   comp_A_addr,
    output logic [BITWIDTH-1:0]   comp_D_addr,
    output logic [BITWIDTH-1:0]   comp_C_addr,
    input  logic                  comp_finished,
    input  logic [1:0]            load_req,
    input  logic [2*BITWIDTH-1:0] load_addrs,
    output logic [1:0]            load_grant,
    output logic                  load_start,
    output logic [BITWIDTH-1:0]   load_B_addr,
    input  logic                  load_finished,
    output logic                  timeout_err
);

    logic [3*BITWIDTH-1:0] comp_payload;
    logic                  comp_timeout;
    logic                  load_timeout;

    rr_lock_channel #(
        .PAYLOAD_W      (3*BITWIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_comp (
        .clock       (clock),
        .reset       (reset),
        .req         (comp_req),
        .payload_in  (comp_addrs),
        .finished    (comp_finished),
        .grant       (comp_grant),
        .start       (comp_start),
        .payload_out (comp_payload),
        .timeout     (comp_timeout)
    );

    rr_lock_channel #(
        .PAYLOAD_W      (BITWIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_load (
        .clock       (clock),
        .reset       (reset),
        .req         (load_req),
        .payload_in  (load_addrs),
        .finished    (load_finished),
        .grant       (load_grant),
        .start       (load_start),
        .payload_out (load_B_addr),
        .timeout     (load_timeout)
    );

    // Payload packing is {C, D, A} per slot.
    assign comp_A_addr = comp_payload[BITWIDTH-1:0];
    assign comp_D_addr = comp_payload[2*BITWIDTH-1:BITWIDTH];
    assign comp_C_addr = comp_payload[3*BITWIDTH-1:2*BITWIDTH];

    // Both channels timing out together yield a single pulse.
    assign timeout_err = comp_timeout | load_timeout;

endmodule
